aes_sbox_sched: RTL

Time-multiplexing scheduler for the single shared `sbox` instance in the low-area AES core. It serialises byte substitutions for two requesters: the data path (SubBytes, one state byte per request) and the key schedule (SubWord, one 32-bit word per request, substituted as four consecutive bytes). Arbitration is fair between requesters, and results return on tagged, registered response ports.

---
 rtl/aes_pkg.sv | 25 ++
 rtl/aes_sbox_sched_if.sv | 34 +++
 rtl/sbox.sv | 30 +++
 rtl/aes_sbox_sched.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: scheduler FSM states, byte/word widths and the
// payload carried from the request mux to the shared sbox.
package aes_pkg;

  localparam int unsigned AES_BYTE_W = 8;
  localparam int unsigned AES_WORD_W = 32;

  // Scheduler states: IDLE streams data bytes, KEY0..KEY3 feed one key byte each
  typedef enum logic [2:0] {
    IDLE,
    KEY0,
    KEY1,
    KEY2,
    KEY3
  } aes_state_e;

  // One byte on its way into the sbox, with its routing information
  typedef struct packed {
    logic                  vld;
    logic                  is_key;
    logic                  last;
    logic [AES_BYTE_W-1:0] byt;
  } sbox_op_t;

endpackage

// File: rtl/aes_sbox_sched_if.sv
// Request/response bundle between the AES requesters and the sbox scheduler.
interface aes_sbox_sched_if #(
  parameter int unsigned IDX_W = 4
);

  logic                             d_req_valid;
  logic                             d_req_ready;
  logic [aes_pkg::AES_BYTE_W-1:0]   d_req_byte;
  logic [IDX_W-1:0]                 d_req_idx;
  logic                             d_rsp_valid;
  logic [aes_pkg::AES_BYTE_W-1:0]   d_rsp_byte;
  logic [IDX_W-1:0]                 d_rsp_idx;
  logic                             k_req_valid;
  logic                             k_req_ready;
  logic [aes_pkg::AES_WORD_W-1:0]   k_req_word;
  logic                             k_rsp_valid;
  logic [aes_pkg::AES_WORD_W-1:0]   k_rsp_word;
  logic                             busy;

  // Requester side
  modport master (
    output d_req_valid, d_req_byte, d_req_idx, k_req_valid, k_req_word,
    input  d_req_ready, d_rsp_valid, d_rsp_byte, d_rsp_idx,
           k_req_ready, k_rsp_valid, k_rsp_word, busy
  );

  // Scheduler side
  modport slave (
    input  d_req_valid, d_req_byte, d_req_idx, k_req_valid, k_req_word,
    output d_req_ready, d_rsp_valid, d_rsp_byte, d_rsp_idx,
           k_req_ready, k_rsp_valid, k_rsp_word, busy
  );

endinterface

// File: rtl/sbox.sv
// AES forward S-box, purely combinational table lookup.
module sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] a,
  output logic [AES_BYTE_W-1:0] y
);

  localparam logic [AES_BYTE_W-1:0] SBOX_TBL [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX_TBL[a];

endmodule

// File: rtl/aes_sbox_sched.sv
// Time-multiplexes the single shared sbox between data-path SubBytes requests
// and key-schedule SubWord requests, with fair arbitration and registered,
// tagged responses. Build option AES_SBOX_PIPE_EN inserts a register between
// the request mux and the sbox input (one extra cycle of latency).
module aes_sbox_sched
  import aes_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  aes_sbox_sched_if.slave bus
);

  aes_state_e              state_q, state_d;
  logic                    prefer_q, prefer_d;
  logic [AES_WORD_W-1:0]   kword_q, kword_d;
  logic                    d_ready_c, k_ready_c;
  sbox_op_t                op_c;
  logic [IDX_W-1:0]        op_idx_c;
  sbox_op_t                stg_c;
  logic [IDX_W-1:0]        stg_idx_c;
  logic [AES_BYTE_W-1:0]   sub_c;
  logic                    busy_d;

  logic                    d_vld_q;
  logic [AES_BYTE_W-1:0]   d_byte_q;
  logic [IDX_W-1:0]        d_idx_q;
  logic                    k_vld_q;
  logic [AES_WORD_W-1:0]   k_word_q;
  logic [3*AES_BYTE_W-1:0] asm_q;
  logic                    busy_q;

  // State, fairness flag and latched key word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prefer_q <= 1'b0;
      kword_q  <= '0;
    end else begin
      state_q  <= state_d;
      prefer_q <= prefer_d;
      kword_q  <= kword_d;
    end
  end

  // Arbitration, next state and sbox input mux
  always_comb begin
    state_d   = state_q;
    prefer_d  = prefer_q;
    kword_d   = kword_q;
    d_ready_c = 1'b0;
    k_ready_c = 1'b0;
    op_c      = '0;
    op_idx_c  = '0;
    case (state_q)
      IDLE: begin
        if (bus.d_req_valid && bus.k_req_valid) begin
          d_ready_c = prefer_q;
          k_ready_c = !prefer_q;
        end else begin
          d_ready_c = 1'b1;
          k_ready_c = 1'b1;
        end
        if (bus.d_req_valid && d_ready_c) begin
          op_c.vld = 1'b1;
          op_c.byt = bus.d_req_byte;
          op_idx_c = bus.d_req_idx;
          prefer_d = 1'b0;
        end
        if (bus.k_req_valid && k_ready_c) begin
          kword_d  = bus.k_req_word;
          prefer_d = 1'b1;
          state_d  = KEY0;
        end
      end
      KEY0: begin
        op_c.vld    = 1'b1;
        op_c.is_key = 1'b1;
        op_c.byt    = kword_q[31:24];
        state_d     = KEY1;
      end
      KEY1: begin
        op_c.vld    = 1'b1;
        op_c.is_key = 1'b1;
        op_c.byt    = kword_q[23:16];
        state_d     = KEY2;
      end
      KEY2: begin
        op_c.vld    = 1'b1;
        op_c.is_key = 1'b1;
        op_c.byt    = kword_q[15:8];
        state_d     = KEY3;
      end
      KEY3: begin
        op_c.vld    = 1'b1;
        op_c.is_key = 1'b1;
        op_c.last   = 1'b1;
        op_c.byt    = kword_q[7:0];
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef AES_SBOX_PIPE_EN
  sbox_op_t         stg_q;
  logic [IDX_W-1:0] stg_idx_q;

  // Pipeline register between the request mux and the sbox
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q     <= '0;
      stg_idx_q <= '0;
    end else begin
      stg_q     <= op_c;
      stg_idx_q <= op_idx_c;
    end
  end

  assign stg_c     = stg_q;
  assign stg_idx_c = stg_idx_q;
  // A byte sitting in the pipe register is still an outstanding job
  assign busy_d    = (state_d != IDLE) || op_c.vld;
`else
  assign stg_c     = op_c;
  assign stg_idx_c = op_idx_c;
  assign busy_d    = (state_d != IDLE);
`endif

  sbox u_sbox (
    .a (stg_c.byt),
    .y (sub_c)
  );

  // Response registers; asm_q collects the first three key bytes MSB first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_vld_q  <= 1'b0;
      d_byte_q <= '0;
      d_idx_q  <= '0;
      k_vld_q  <= 1'b0;
      k_word_q <= '0;
      asm_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      d_vld_q <= stg_c.vld && !stg_c.is_key;
      k_vld_q <= stg_c.vld && stg_c.is_key && stg_c.last;
      busy_q  <= busy_d;
      if (stg_c.vld && !stg_c.is_key) begin
        d_byte_q <= sub_c;
        d_idx_q  <= stg_idx_c;
      end
      if (stg_c.vld && stg_c.is_key) begin
        asm_q <= {asm_q[2*AES_BYTE_W-1:0], sub_c};
        if (stg_c.last) begin
          k_word_q <= {asm_q, sub_c};
        end
      end
    end
  end

  assign bus.d_req_ready = d_ready_c;
  assign bus.k_req_ready = k_ready_c;
  assign bus.d_rsp_valid = d_vld_q;
  assign bus.d_rsp_byte  = d_byte_q;
  assign bus.d_rsp_idx   = d_idx_q;
  assign bus.k_rsp_valid = k_vld_q;
  assign bus.k_rsp_word  = k_word_q;
  assign bus.busy        = busy_q;

endmodule
